// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian words, then resets, bursts and releases the CPU.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        CpuReset,
  output logic        LoadInstructions,
  output logic [31:0] Instruction,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    HDR,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    CLR,
    BURST,
    REL,
    RUN
  } state_t;

  state_t         state;
  logic [AW-1:0]  nm1;
  logic [AW-1:0]  widx;
  logic [AW-1:0]  ridx;
  logic [1:0]     bcnt;
  logic [23:0]    word;
  logic [31:0]    mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]     csum;
`endif

  logic hdr_ok;
  logic word_done;

  assign hdr_ok    = (byte_in != 8'd0) && (int'(byte_in) <= DEPTH);
  assign word_done = (state == DATA) && byte_valid && (bcnt == 2'd3);

  // Every output is a decode of registered state, so nothing depends on byte_valid combinationally.
  assign byte_ready       = (state == HDR) || (state == DATA) || (state == RUN)
`ifdef LOADER_CHECKSUM_EN
                            || (state == CSUM)
`endif
                            ;
  assign CpuReset         = (state != BURST) && (state != RUN);
  assign LoadInstructions = (state == BURST);
  assign busy             = (state != RUN);
  assign Instruction      = (state == BURST) ? mem[ridx] : 32'd0;

  always_ff @(posedge clk) begin
    if (!Reset && word_done) mem[widx] <= {word, byte_in};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= HDR;
      err   <= 1'b0;
      nm1   <= '0;
      widx  <= '0;
      ridx  <= '0;
      bcnt  <= 2'd0;
      word  <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      csum  <= 8'd0;
`endif
    end else begin
      case (state)
        HDR, RUN: begin
          if (byte_valid) begin
            if (hdr_ok) begin
              nm1   <= AW'(byte_in - 8'd1);
              err   <= 1'b0;
              widx  <= '0;
              ridx  <= '0;
              bcnt  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
              csum  <= 8'd0;
`endif
              state <= DATA;
            end else begin
              err   <= 1'b1;
              state <= HDR;
            end
          end
        end
        DATA: begin
          if (byte_valid) begin
            bcnt <= bcnt + 2'd1;
            word <= {word[15:0], byte_in};
`ifdef LOADER_CHECKSUM_EN
            csum <= csum + byte_in;
`endif
            if (bcnt == 2'd3) begin
              widx <= widx + AW'(1);
              if (widx == nm1) begin
`ifdef LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state <= CLR;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (byte_valid) begin
            if (byte_in == csum) state <= CLR;
            else begin
              err   <= 1'b1;
              state <= HDR;
            end
          end
        end
`endif
        CLR: begin
          ridx  <= '0;
          state <= BURST;
        end
        BURST: begin
          ridx <= ridx + AW'(1);
          if (ridx == nm1) state <= REL;
        end
        REL:     state <= RUN;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: header table, hand sequences and randomized loads
// checked against word lists and the load-sequence timing rules.
module tb_program_loader;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, CpuReset, LoadInstructions, busy, err;
  logic [31:0] Instruction;

  program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .Reset(Reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .CpuReset(CpuReset), .LoadInstructions(LoadInstructions),
    .Instruction(Instruction), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];

  typedef struct {
    logic [7:0] b;
    logic       exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) step();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 200 && !byte_ready; t++) step();
    chk("ready_wait", {31'd0, byte_ready}, 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] payload_sum();
    logic [7:0] s = 8'd0;
    foreach (wq[i]) s = s + wq[i][31:24] + wq[i][23:16] + wq[i][15:8] + wq[i][7:0];
    return s;
  endfunction

  task automatic send_payload(input int maxgap);
    foreach (wq[i])
      for (int j = 3; j >= 0; j--)
        send_byte(wq[i][j*8 +: 8], $urandom_range(0, maxgap));
`ifdef LOADER_CHECKSUM_EN
    send_byte(payload_sum(), $urandom_range(0, maxgap));
`endif
  endtask

  task automatic send_prog(input int maxgap);
    send_byte(8'(wq.size()), $urandom_range(0, maxgap));
    chk("hdr_crst", {31'd0, CpuReset}, 32'd1);
    chk("hdr_busy", {31'd0, busy}, 32'd1);
    chk("hdr_err", {31'd0, err}, 32'd0);
    chk("hdr_ld", {31'd0, LoadInstructions}, 32'd0);
    send_payload(maxgap);
  endtask

  // Called with the sample just after the edge that accepted the final stream byte.
  task automatic expect_load(input logic hold);
    if (hold) begin
      byte_in    = 8'h01;
      byte_valid = 1'b1;
    end
    chk("clr_ready", {31'd0, byte_ready}, 32'd0);
    chk("clr_crst", {31'd0, CpuReset}, 32'd1);
    chk("clr_ld", {31'd0, LoadInstructions}, 32'd0);
    chk("clr_instr", Instruction, 32'd0);
    step();
    foreach (wq[k]) begin
      chk("burst_ld", {31'd0, LoadInstructions}, 32'd1);
      chk("burst_crst", {31'd0, CpuReset}, 32'd0);
      chk("burst_ready", {31'd0, byte_ready}, 32'd0);
      chk("burst_instr", Instruction, wq[k]);
      step();
    end
    chk("rel_ld", {31'd0, LoadInstructions}, 32'd0);
    chk("rel_crst", {31'd0, CpuReset}, 32'd1);
    chk("rel_ready", {31'd0, byte_ready}, 32'd0);
    chk("rel_busy", {31'd0, busy}, 32'd1);
    step();
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_crst", {31'd0, CpuReset}, 32'd0);
    chk("run_ld", {31'd0, LoadInstructions}, 32'd0);
    chk("run_ready", {31'd0, byte_ready}, 32'd1);
    chk("run_instr", Instruction, 32'd0);
    chk("run_err", {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd0,   1'b1};
    vecs[1] = '{8'd33,  1'b1};
    vecs[2] = '{8'd255, 1'b1};
    vecs[3] = '{8'd1,   1'b0};
    vecs[4] = '{8'hDE,  1'b0};
    vecs[5] = '{8'hAD,  1'b0};
    vecs[6] = '{8'hBE,  1'b0};
    vecs[7] = '{8'hEF,  1'b0};

    // Reset values
    step();
    step();
    chk("rst_ready", {31'd0, byte_ready}, 32'd1);
    chk("rst_crst", {31'd0, CpuReset}, 32'd1);
    chk("rst_ld", {31'd0, LoadInstructions}, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    Reset = 1'b0;
    step();

    // Basic load
    wq = '{32'h20010005, 32'h00221820};
    send_prog(0);
    expect_load(1'b0);

    // Header table from a fresh reset, then a 1-word program
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].b, 0);
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("tbl%0d_crst", i), {31'd0, CpuReset}, 32'd1);
      chk($sformatf("tbl%0d_ld", i), {31'd0, LoadInstructions}, 32'd0);
    end
    wq = '{32'hDEADBEEF};
`ifdef LOADER_CHECKSUM_EN
    send_byte(payload_sum(), 0);
`endif
    expect_load(1'b0);

    // Valid toggling, then a header held across CLR/BURST/REL
    wq = '{32'hDEADBEEF};
    send_byte(8'd1, 1);
    for (int j = 3; j >= 0; j--) send_byte(wq[0][j*8 +: 8], 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(payload_sum(), 1);
`endif
    expect_load(1'b1);
    step();
    byte_valid = 1'b0;
    chk("held_hdr_crst", {31'd0, CpuReset}, 32'd1);
    chk("held_hdr_busy", {31'd0, busy}, 32'd1);
    chk("held_hdr_ready", {31'd0, byte_ready}, 32'd1);
    wq = '{32'h08000000};
    send_payload(0);
    expect_load(1'b0);

    // Reload from RUN
    wq = '{32'h08000000};
    send_prog(0);
    expect_load(1'b0);

`ifdef LOADER_CHECKSUM_EN
    wq = '{32'h01020304};
    send_byte(8'd1, 0);
    for (int j = 3; j >= 0; j--) send_byte(wq[0][j*8 +: 8], 0);
    send_byte(8'h0B, 0);
    chk("csum_bad_err", {31'd0, err}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("csum_bad_ld", {31'd0, LoadInstructions}, 32'd0);
      chk("csum_bad_crst", {31'd0, CpuReset}, 32'd1);
      step();
    end
    chk("csum_sum", {24'd0, payload_sum()}, 32'h0A);
    send_prog(0);
    expect_load(1'b0);
`endif

    // Randomized loads against the word list
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom());
      send_prog(2);
      expect_load(1'b0);
    end

    // Reset in burst cycle 5 of a full-depth program
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom());
    send_prog(0);
    step();
    for (int k = 0; k < 5; k++) step();
    chk("mid_burst_instr", Instruction, wq[5]);
    chk("mid_burst_ld", {31'd0, LoadInstructions}, 32'd1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid_rst_ld", {31'd0, LoadInstructions}, 32'd0);
    chk("mid_rst_crst", {31'd0, CpuReset}, 32'd1);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_ready", {31'd0, byte_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_instr", Instruction, 32'd0);

    wq = '{32'h20010005, 32'h00221820};
    send_prog(1);
    expect_load(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
